rdyack_in_array: RTL and testbench

Parametrised multi-channel input level-transition indicator for the MMU's RDYIN (P -> MMU) and ACKIN (MM -> MMU) interfaces. Each channel detects a pending event when its synchronised incoming line differs from a local modulo-2 counter. The local counter toggles when the event is consumed through `beta`. The block adds input synchronisers, reset alignment, lowest-index channel selection, and per-channel sticky protocol-error flags.

---
 rtl/rdyack_in_array.sv | 99 +++++++++
 tb/tb_rdyack_in_array.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/rdyack_in_array.sv
// Multi-channel level-transition event detector for the RDYIN/ACKIN interfaces.
// Each channel flags a pending event while its synchronised line differs from a local toggle counter.
module rdyack_in_array #(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned IDX_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_CH-1:0]  linea,
  input  logic [N_CH-1:0]  beta,
  input  logic             beta_sel,
  output logic [N_CH-1:0]  rdyackin,
  output logic             sel_valid,
  output logic [IDX_W-1:0] sel_idx,
  output logic [N_CH-1:0]  err,
  output logic             init
);

  localparam int unsigned InitW = $clog2(SYNC_STAGES + 1);

  logic [N_CH-1:0]  sync_q [SYNC_STAGES];
  logic [N_CH-1:0]  sync_d [SYNC_STAGES];
  logic [N_CH-1:0]  cnt_q, cnt_d;
  logic [N_CH-1:0]  err_q, err_d;
  logic [InitW-1:0] init_left_q, init_left_d;

  logic [N_CH-1:0]  s, s_next;
  logic [N_CH-1:0]  pending;
  logic [N_CH-1:0]  consume;

  always_comb begin
    sync_d[0] = linea;
    for (int j = 1; j < int'(SYNC_STAGES); j++) begin
      sync_d[j] = sync_q[j-1];
    end
  end

  assign s      = sync_q[SYNC_STAGES-1];
  assign s_next = sync_d[SYNC_STAGES-1];

  assign init    = (init_left_q != '0);
  assign pending = (s ^ cnt_q) & {N_CH{~init}};

  // Priority encoder: scanning downwards leaves the lowest pending index.
  always_comb begin
    sel_valid = |pending;
    sel_idx   = '0;
    for (int i = int'(N_CH) - 1; i >= 0; i--) begin
      if (pending[i]) begin
        sel_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    consume = '0;
    for (int i = 0; i < int'(N_CH); i++) begin
      consume[i] = beta[i] | (beta_sel & sel_valid & (sel_idx == IDX_W'(i)));
    end
  end

  always_comb begin
    cnt_d       = cnt_q;
    err_d       = err_q;
    init_left_d = init_left_q;
    if (init) begin
      // Track the line so levels present at reset never surface as events.
      cnt_d       = s_next;
      init_left_d = init_left_q - InitW'(1);
    end else begin
      cnt_d = cnt_q ^ (consume & pending);
      // Stray consume, or a second toggle arriving before the first was consumed.
      err_d = err_q | (consume & ~pending) | ((s_next ^ s) & pending & ~consume);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int j = 0; j < int'(SYNC_STAGES); j++) begin
        sync_q[j] <= linea;
      end
      cnt_q       <= linea;
      err_q       <= '0;
      init_left_q <= InitW'(SYNC_STAGES);
    end else begin
      for (int j = 0; j < int'(SYNC_STAGES); j++) begin
        sync_q[j] <= sync_d[j];
      end
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      init_left_q <= init_left_d;
    end
  end

  assign rdyackin = pending;
  assign err      = err_q;

endmodule

// File: tb/tb_rdyack_in_array.sv
// Directed bench for rdyack_in_array with N_CH=4, SYNC_STAGES=2.
module tb_rdyack_in_array;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] linea;
  logic [3:0] beta;
  logic       beta_sel;
  logic [3:0] rdyackin;
  logic       sel_valid;
  logic [1:0] sel_idx;
  logic [3:0] err;
  logic       init;

  int vectors    = 0;
  int miscompares = 0;

  rdyack_in_array #(
    .N_CH       (4),
    .SYNC_STAGES(2),
    .IDX_W      (2)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .linea    (linea),
    .beta     (beta),
    .beta_sel (beta_sel),
    .rdyackin (rdyackin),
    .sel_valid(sel_valid),
    .sel_idx  (sel_idx),
    .err      (err),
    .init     (init)
  );

  always #5 clock = ~clock;

  // Advance one rising edge and settle away from it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; linea = 4'b1010; beta = '0; beta_sel = 1'b0;
    step(); step();
    vectors++;
    if (init !== 1'b1) begin miscompares++; $display("FAIL rst_init got %b want 1", init); end
    vectors++;
    if ({rdyackin, sel_valid, sel_idx} !== 7'b0) begin
      miscompares++;
      $display("FAIL rst_outs got %b/%b/%0d want 0/0/0", rdyackin, sel_valid, sel_idx);
    end
    reset = 1'b0;
    beta = 4'hf; beta_sel = 1'b1;  // must be ignored during alignment
    vectors++;
    if (init !== 1'b1) begin miscompares++; $display("FAIL align0_init got %b want 1", init); end
    step();
    vectors++;
    if (init !== 1'b1) begin miscompares++; $display("FAIL align1_init got %b want 1", init); end
    step();
    beta = '0; beta_sel = 1'b0;
    vectors++;
    if (init !== 1'b0) begin miscompares++; $display("FAIL align_done got %b want 0", init); end
    vectors++;
    if (rdyackin !== 4'b0 || err !== 4'b0) begin
      miscompares++;
      $display("FAIL align_clean got rdy=%b err=%b want 0000/0000", rdyackin, err);
    end
  endtask

  task automatic test_single_event();
    linea = linea ^ 4'b0100;
    step();
    vectors++;
    if (rdyackin !== 4'b0000) begin
      miscompares++; $display("FAIL single_early got %b want 0000", rdyackin);
    end
    step();
    vectors++;
    if (rdyackin !== 4'b0100 || sel_idx !== 2'd2 || sel_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL single_set got %b/%0d/%b want 0100/2/1", rdyackin, sel_idx, sel_valid);
    end
    beta_sel = 1'b1;
    step();
    beta_sel = 1'b0;
    vectors++;
    if (rdyackin !== 4'b0000 || err !== 4'b0000) begin
      miscompares++;
      $display("FAIL single_consume got rdy=%b err=%b want 0000/0000", rdyackin, err);
    end
  endtask

  task automatic test_priority();
    linea = linea ^ 4'b1010;
    step(); step();
    vectors++;
    if (rdyackin !== 4'b1010 || sel_idx !== 2'd1) begin
      miscompares++; $display("FAIL prio_first got %b/%0d want 1010/1", rdyackin, sel_idx);
    end
    beta_sel = 1'b1;
    step();
    beta_sel = 1'b0;
    vectors++;
    if (rdyackin !== 4'b1000 || sel_idx !== 2'd3 || sel_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL prio_second got %b/%0d/%b want 1000/3/1", rdyackin, sel_idx, sel_valid);
    end
    beta_sel = 1'b1;
    step();
    beta_sel = 1'b0;
    vectors++;
    if (sel_valid !== 1'b0 || sel_idx !== 2'd0 || err !== 4'b0) begin
      miscompares++;
      $display("FAIL prio_empty got %b/%0d err=%b want 0/0/0000", sel_valid, sel_idx, err);
    end
  endtask

  task automatic test_simultaneous();
    linea = linea ^ 4'b0001;
    step(); step();
    linea = linea ^ 4'b0001;
    step();
    beta[0] = 1'b1;  // consume on the same edge the second toggle reaches s[0]
    step();
    beta[0] = 1'b0;
    vectors++;
    if (rdyackin[0] !== 1'b1 || err[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL simul_keep got rdy0=%b err0=%b want 1/0", rdyackin[0], err[0]);
    end
    beta[0] = 1'b1;
    step();
    beta[0] = 1'b0;
    vectors++;
    if (rdyackin !== 4'b0000 || err !== 4'b0000) begin
      miscompares++;
      $display("FAIL simul_drain got rdy=%b err=%b want 0000/0000", rdyackin, err);
    end
  endtask

  task automatic test_lost_event();
    linea = linea ^ 4'b0010;
    step(); step();
    vectors++;
    if (rdyackin[1] !== 1'b1) begin
      miscompares++; $display("FAIL lost_first got %b want 1", rdyackin[1]);
    end
    step();
    linea = linea ^ 4'b0010;
    step(); step();
    vectors++;
    if (rdyackin[1] !== 1'b0 || err !== 4'b0010) begin
      miscompares++;
      $display("FAIL lost_collapse got rdy1=%b err=%b want 0/0010", rdyackin[1], err);
    end
    repeat (4) step();
    vectors++;
    if (err !== 4'b0010) begin miscompares++; $display("FAIL lost_sticky got %b want 0010", err); end
  endtask

  task automatic test_stray_beta();
    beta[3] = 1'b1;
    step();
    beta[3] = 1'b0;
    vectors++;
    if (err !== 4'b1010 || rdyackin !== 4'b0000) begin
      miscompares++;
      $display("FAIL stray_err got err=%b rdy=%b want 1010/0000", err, rdyackin);
    end
    linea = linea ^ 4'b1000;
    step(); step();
    vectors++;
    if (rdyackin !== 4'b1000 || sel_idx !== 2'd3) begin
      miscompares++; $display("FAIL stray_cnt got %b/%0d want 1000/3", rdyackin, sel_idx);
    end
  endtask

  task automatic test_reset_midop();
    reset = 1'b1;
    step();
    linea = linea ^ 4'b0001;  // toggle during reset must be absorbed
    step();
    vectors++;
    if (err !== 4'b0000 || rdyackin !== 4'b0000 || init !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst got err=%b rdy=%b init=%b want 0000/0000/1", err, rdyackin, init);
    end
    reset = 1'b0;
    step(); step();
    vectors++;
    if (init !== 1'b0 || rdyackin !== 4'b0000 || err !== 4'b0000) begin
      miscompares++;
      $display("FAIL midrst_align got init=%b rdy=%b err=%b want 0/0000/0000", init, rdyackin, err);
    end
    linea = linea ^ 4'b0001;
    step(); step();
    vectors++;
    if (rdyackin !== 4'b0001 || sel_idx !== 2'd0 || sel_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_event got %b/%0d/%b want 0001/0/1", rdyackin, sel_idx, sel_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single_event();
    test_priority();
    test_simultaneous();
    test_lost_event();
    test_stray_beta();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
